// File: rtl/ntt_ctrl.sv
// Address/control sequencer for a 256-point, 7-layer NTT/INTT with a single butterfly unit.
// Optional hold-based stall is compiled in with `define NTT_CTRL_STALL_EN.
module ntt_ctrl #(
  parameter int BF_LAT  = 3,
  parameter int RAM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mode,
`ifdef NTT_CTRL_STALL_EN
  input  logic       hold,
`endif
  output logic       rd_en,
  output logic [7:0] rd_addr_a,
  output logic [7:0] rd_addr_b,
  output logic [6:0] tw_addr,
  output logic [1:0] bf_sel,
  output logic       wr_en,
  output logic [7:0] wr_addr_a,
  output logic [7:0] wr_addr_b,
  output logic       busy,
  output logic       done
);

  localparam int D = RAM_LAT + BF_LAT;
  localparam logic [3:0] DLAST = 4'(D - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t     state_q;
  logic [2:0] layer_q;
  logic [6:0] b_q;
  logic [3:0] dcnt_q;
  logic       mode_q;
  logic       busy_q;
  logic       done_q;
  logic       rd_en_q;
  logic [7:0] rd_a_q;
  logic [7:0] rd_b_q;
  logic [6:0] tw_q;

  logic       dly_vld_q [D];
  logic [7:0] dly_a_q   [D];
  logic [7:0] dly_b_q   [D];

  logic       stall;

`ifdef NTT_CTRL_STALL_EN
  assign stall = hold && ((state_q == RUN) || (state_q == DRAIN));
`else
  assign stall = 1'b0;
`endif

  function automatic logic [3:0] stride_f(input logic [2:0] l, input logic m);
    return m ? ({1'b0, l} + 4'd1) : (4'd7 - {1'b0, l});
  endfunction

  function automatic logic [7:0] addr_a_f(input logic [2:0] l, input logic [6:0] b, input logic m);
    logic [3:0] s;
    logic [7:0] bw;
    s  = stride_f(l, m);
    bw = {1'b0, b};
    return ((bw >> s) << (s + 4'd1)) | (bw & ((8'd1 << s) - 8'd1));
  endfunction

  function automatic logic [7:0] addr_b_f(input logic [2:0] l, input logic [6:0] b, input logic m);
    return addr_a_f(l, b, m) + (8'd1 << stride_f(l, m));
  endfunction

  // Forward walks the twiddle table upward per layer; inverse walks it downward.
  function automatic logic [6:0] tw_f(input logic [2:0] l, input logic [6:0] b, input logic m);
    logic [3:0] s;
    logic [7:0] grp;
    logic [7:0] t;
    s   = stride_f(l, m);
    grp = {1'b0, b} >> s;
    if (m) t = (8'd1 << (4'd8 - s)) - 8'd1 - grp;
    else   t = (8'd1 << l) + grp;
    return t[6:0];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      layer_q <= '0;
      b_q     <= '0;
      dcnt_q  <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else if (!stall) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            mode_q  <= mode;
            layer_q <= '0;
            b_q     <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            rd_a_q  <= addr_a_f(3'd0, 7'd0, mode);
            rd_b_q  <= addr_b_f(3'd0, 7'd0, mode);
            tw_q    <= tw_f(3'd0, 7'd0, mode);
          end
        end
        RUN: begin
          if (b_q == 7'd127) begin
            state_q <= DRAIN;
            dcnt_q  <= '0;
            rd_en_q <= 1'b0;
          end else begin
            b_q     <= b_q + 7'd1;
            rd_en_q <= 1'b1;
            rd_a_q  <= addr_a_f(layer_q, b_q + 7'd1, mode_q);
            rd_b_q  <= addr_b_f(layer_q, b_q + 7'd1, mode_q);
            tw_q    <= tw_f(layer_q, b_q + 7'd1, mode_q);
          end
        end
        DRAIN: begin
          // Reads of the next layer wait until every write of this layer has landed.
          if (dcnt_q == DLAST) begin
            if (layer_q == 3'd6) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              layer_q <= layer_q + 3'd1;
              b_q     <= '0;
              rd_en_q <= 1'b1;
              rd_a_q  <= addr_a_f(layer_q + 3'd1, 7'd0, mode_q);
              rd_b_q  <= addr_b_f(layer_q + 3'd1, 7'd0, mode_q);
              tw_q    <= tw_f(layer_q + 3'd1, 7'd0, mode_q);
            end
          end else begin
            dcnt_q <= dcnt_q + 4'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) begin
        dly_vld_q[i] <= 1'b0;
        dly_a_q[i]   <= '0;
        dly_b_q[i]   <= '0;
      end
    end else if (!stall) begin
      dly_vld_q[0] <= rd_en_q;
      dly_a_q[0]   <= rd_a_q;
      dly_b_q[0]   <= rd_b_q;
      for (int i = 1; i < D; i++) begin
        dly_vld_q[i] <= dly_vld_q[i-1];
        dly_a_q[i]   <= dly_a_q[i-1];
        dly_b_q[i]   <= dly_b_q[i-1];
      end
    end
  end

  assign rd_en     = rd_en_q & ~stall;
  assign rd_addr_a = rd_a_q;
  assign rd_addr_b = rd_b_q;
  assign tw_addr   = tw_q;
  assign bf_sel    = (dly_vld_q[RAM_LAT-1] && !stall) ? {1'b0, mode_q} : 2'd2;
  assign wr_en     = dly_vld_q[D-1] & ~stall;
  assign wr_addr_a = dly_a_q[D-1];
  assign wr_addr_b = dly_b_q[D-1];
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Self-checking bench for ntt_ctrl: cycle-by-cycle comparison against an arithmetic schedule model.
module tb_ntt_ctrl;
  localparam int BF_LAT  = 3;
  localparam int RAM_LAT = 1;
  localparam int D       = RAM_LAT + BF_LAT;
  localparam int P       = 128 + D;
  localparam int LAST    = 7 * P + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       mode;
`ifdef NTT_CTRL_STALL_EN
  logic       hold;
`endif
  logic       rd_en;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic [6:0] tw_addr;
  logic [1:0] bf_sel;
  logic       wr_en;
  logic [7:0] wr_addr_a;
  logic [7:0] wr_addr_b;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ntt_ctrl #(.BF_LAT(BF_LAT), .RAM_LAT(RAM_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
`ifdef NTT_CTRL_STALL_EN
    .hold      (hold),
`endif
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_addr   (tw_addr),
    .bf_sel    (bf_sel),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue slot e (cycles after the start edge) -> layer and butterfly index.
  function automatic bit issue_at(input int e, output int l, output int b);
    l = 0;
    b = 0;
    if (e < 1 || e > 7 * P) return 1'b0;
    l = (e - 1) / P;
    b = (e - 1) % P;
    return (b < 128);
  endfunction

  function automatic void pair(input logic m, input int l, input int b,
                               output int a, output int bb, output int tw);
    int s, len, grp;
    s   = m ? l + 1 : 7 - l;
    len = 1 << s;
    grp = b / len;
    a   = grp * 2 * len + b % len;
    bb  = a + len;
    tw  = m ? (1 << (8 - s)) - 1 - grp : (1 << l) + grp;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_rd_a"},  32'(rd_addr_a), 32'd0);
    chk({tag, "_rd_b"},  32'(rd_addr_b), 32'd0);
    chk({tag, "_tw"},    32'(tw_addr), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_wr_a"},  32'(wr_addr_a), 32'd0);
    chk({tag, "_wr_b"},  32'(wr_addr_b), 32'd0);
    chk({tag, "_bfsel"}, 32'(bf_sel), 32'd2);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
  endtask

  task automatic run_xfer(input logic m, input int ign_c, input int rst_c, input int h0, input int hl);
    int  wr_cnt, done_c, c_end, e, l, b, a, bb, tw;
    bit  iss, wiss, biss;
    logic hld;
    wr_cnt = 0;
    done_c = -1;
    c_end  = (rst_c > 0) ? rst_c : LAST + hl + 1;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    for (int c = 1; c <= c_end; c++) begin
      @(negedge clk);
      start = (c == ign_c);
      mode  = 1'($urandom_range(0, 1));
      hld   = (hl > 0) && (c >= h0) && (c < h0 + hl);
`ifdef NTT_CTRL_STALL_EN
      hold  = hld;
`endif
      if (c == rst_c) rst = 1'b0;
      #1;
      if (c == rst_c) begin
        check_reset_outputs("rst_mid");
        break;
      end
      if (hld) begin
        chk("hold_rd_en", 32'(rd_en), 32'd0);
        chk("hold_wr_en", 32'(wr_en), 32'd0);
        chk("hold_bfsel", 32'(bf_sel), 32'd2);
        chk("hold_busy",  32'(busy), 32'd1);
        continue;
      end
      e = (hl > 0 && c >= h0 + hl) ? c - hl : c;
      iss = issue_at(e, l, b);
      chk("rd_en", 32'(rd_en), 32'(iss));
      if (iss) begin
        pair(m, l, b, a, bb, tw);
        chk("rd_addr_a", 32'(rd_addr_a), 32'(a));
        chk("rd_addr_b", 32'(rd_addr_b), 32'(bb));
        chk("tw_addr",   32'(tw_addr), 32'(tw));
      end
      wiss = issue_at(e - D, l, b);
      chk("wr_en", 32'(wr_en), 32'(wiss));
      if (wiss) begin
        pair(m, l, b, a, bb, tw);
        chk("wr_addr_a", 32'(wr_addr_a), 32'(a));
        chk("wr_addr_b", 32'(wr_addr_b), 32'(bb));
      end
      biss = issue_at(e - RAM_LAT, l, b);
      chk("bf_sel", 32'(bf_sel), biss ? 32'(m) : 32'd2);
      chk("busy",   32'(busy), 32'(e <= LAST));
      chk("done",   32'(done), 32'(e == LAST));
      if (hl == 0 && m == 1'b0 && c == 1) begin
        chk("ntt_first_a", 32'(rd_addr_a), 32'd0);
        chk("ntt_first_b", 32'(rd_addr_b), 32'd128);
        chk("ntt_first_tw", 32'(tw_addr), 32'd1);
      end
      if (hl == 0 && m == 1'b0 && c == 1 + 6 * P + 5) begin
        chk("ntt_l6b5_a", 32'(rd_addr_a), 32'd9);
        chk("ntt_l6b5_b", 32'(rd_addr_b), 32'd11);
        chk("ntt_l6b5_tw", 32'(tw_addr), 32'd66);
      end
      if (hl == 0 && m == 1'b1 && c == 1) begin
        chk("intt_first_a", 32'(rd_addr_a), 32'd0);
        chk("intt_first_b", 32'(rd_addr_b), 32'd2);
        chk("intt_first_tw", 32'(tw_addr), 32'd127);
      end
      if (hl == 0 && m == 1'b1 && c == 1 + 6 * P + 127) begin
        chk("intt_last_a", 32'(rd_addr_a), 32'd127);
        chk("intt_last_b", 32'(rd_addr_b), 32'd255);
        chk("intt_last_tw", 32'(tw_addr), 32'd1);
      end
      if (wr_en === 1'b1) wr_cnt++;
      if (done === 1'b1) done_c = c;
    end
`ifdef NTT_CTRL_STALL_EN
    hold = 1'b0;
`endif
    start = 1'b0;
    if (rst_c > 0) begin
      repeat (2) begin
        @(negedge clk);
        #1;
        check_reset_outputs("rst_hold");
      end
      rst = 1'b1;
      repeat (10) begin
        @(negedge clk);
        #1;
        chk("post_rst_wr_en", 32'(wr_en), 32'd0);
        chk("post_rst_rd_en", 32'(rd_en), 32'd0);
        chk("post_rst_busy",  32'(busy), 32'd0);
        chk("post_rst_bfsel", 32'(bf_sel), 32'd2);
      end
    end else begin
      chk("wr_total",   32'(wr_cnt), 32'd896);
      chk("done_cycle", 32'(done_c), 32'(LAST + hl));
    end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
`ifdef NTT_CTRL_STALL_EN
    hold  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(1'b0, 300, 0, 0, 0);
    repeat ($urandom_range(1, 5)) @(negedge clk);
    run_xfer(1'b1, $urandom_range(2, LAST), 0, 0, 0);
    run_xfer(1'($urandom_range(0, 1)), 0, 400, 0, 0);
    run_xfer(1'($urandom_range(0, 1)), $urandom_range(2, LAST), 0, 0, 0);
`ifdef NTT_CTRL_STALL_EN
    run_xfer(1'($urandom_range(0, 1)), 0, 0, 1 + 3 * P + 20, 10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
